pll_lock_seq: RTL

Reset and lock supervisor for one core PLL. It sequences the PLL reset pulse and waits for `locked` with a timeout. It then requires lock to stay stable before releasing the core reset, and re-sequences the PLL on lock loss, with bounded retries. It sits between the board reset and the PLL wrapper, and drives the PLL `rst` input and the active-low reset of every core-side consumer of the PLL output clock.

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/pll_lock_sync.sv | 24 ++
 rtl/pll_lock_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer and its wrappers.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_seq_state_t;

    localparam int RETRY_W = 3;

    // Width needed to count up to the largest terminal count.
    function automatic int pll_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop bit synchronizer with synchronous active-low reset to 0.
module pll_lock_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for a stable lock, then
// releases the core reset; re-sequences on lock loss with bounded retries.
//
// state     | meaning
// RESET     | pll_rst high for RST_CYCLES
// WAIT_LOCK | waiting for lock_s, bounded by LOCK_TIMEOUT
// STABLE    | lock_s must hold for LOCK_STABLE cycles
// RUN       | core out of reset, ready
// FAULT     | retries exhausted, PLL held in reset until relock_req
module pll_lock_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 4
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               core_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_W = pll_cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEO_TC  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_SAT = RETRY_W'(MAX_RETRY - 1);

    pll_seq_state_t     r_state;
    pll_seq_state_t     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               w_lock_s;
    logic               w_fail;
    logic               w_cnt_clr;
    logic               w_cnt_run;

    pll_lock_sync u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_lock_s)
    );

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state <= RESET;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_fail      = 1'b0;
        case (r_state)
            RESET: begin
                if (r_cnt == RST_TC) w_state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lock_s)                w_state_nxt = STABLE;
                else if (r_cnt == TIMEO_TC)  w_fail = 1'b1;
            end
            STABLE: begin
                if (!w_lock_s)               w_fail = 1'b1;
                else if (r_cnt == STABLE_TC) w_state_nxt = RUN;
            end
            RUN: begin
                // Lock loss from RUN never escalates to FAULT; the count saturates.
                if (!w_lock_s) begin
                    w_state_nxt = RESET;
                    if (r_retry < RETRY_SAT) w_retry_nxt = r_retry + RETRY_W'(1);
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = RESET;
            end
        endcase

        if (w_fail) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_state_nxt = (w_retry_nxt == RETRY_MAX) ? FAULT : RESET;
        end

        if (relock_req) begin
            w_state_nxt = RESET;
            w_retry_nxt = '0;
        end
    end

    // relock_req in RESET must restart the pulse even without a state change.
    assign w_cnt_clr = (w_state_nxt != r_state) || relock_req;
    assign w_cnt_run = (r_state == RESET) || (r_state == WAIT_LOCK) || (r_state == STABLE);

    always_ff @(posedge refclk) begin
        if (!rst_n)         r_cnt <= '0;
        else if (w_cnt_clr) r_cnt <= '0;
        else if (w_cnt_run) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign pll_rst    = (r_state == RESET) || (r_state == FAULT);
    assign core_rst_n = (r_state == RUN);
    assign ready      = (r_state == RUN);
    assign fault      = (r_state == FAULT);
    assign retry_cnt  = r_retry;

endmodule
